// File: rtl/philv_trace_pkg.sv
// Shared types for the Philosophy V trace unit.
// States, record layout and record width.
package philv_trace_pkg;

    localparam int TRACE_XLEN    = 32;
    localparam int TRACE_INSTR_W = 32;
    localparam int TRACE_REC_W   = 2*TRACE_XLEN + TRACE_INSTR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_XLEN-1:0]    pc;
        logic [TRACE_INSTR_W-1:0] instr;
        logic [TRACE_XLEN-1:0]    alu;
    } trace_rec_t;

endpackage

// File: rtl/philv_trace_ram.sv
// Trace record storage: one sync write port,
// asynchronous read, no reset on the array.
module philv_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 96
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // write one record per enabled cycle
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/philv_trace_unit.sv
// Run-control and trace capture beside philosophy_v_core.
// Optional PC trigger arming: PHILV_TRACE_TRIG_EN.
module philv_trace_unit
    import philv_trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CYC_W = 16
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       start,
    input  logic [CYC_W-1:0]           cycle_limit,
    input  logic                       wrap_mode,
    output logic                       core_en,
    input  logic                       tr_valid,
    input  logic [XLEN-1:0]            tr_pc,
    input  logic [31:0]                tr_instr,
    input  logic [XLEN-1:0]            tr_alu,
`ifdef PHILV_TRACE_TRIG_EN
    input  logic [XLEN-1:0]            trig_pc,
`endif
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [2*XLEN+31:0]         rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int RW = 2*XLEN + TRACE_INSTR_W;

    trace_state_t   state, state_nxt;
    logic           go, stop, wr, pop, full;
    logic [CYC_W-1:0] cyc, lim;
    logic           wrap;
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  cnt;
    logic           ovf_q;
    logic [RW-1:0]  rdat;

    assign full = (cnt == CW'(DEPTH));

`ifdef PHILV_TRACE_TRIG_EN
    logic armed;
    logic hit;

    assign hit = tr_valid && (tr_pc == trig_pc);
    assign wr  = (state == ST_RUN) && tr_valid
               && (armed || hit);

    // arm on first trigger PC match, disarm on start
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)                      armed <= 1'b0;
        else if (go)                   armed <= 1'b0;
        else if (state == ST_RUN && hit) armed <= 1'b1;
    end
`else
    assign wr = (state == ST_RUN) && tr_valid;
`endif

    assign pop = (state == ST_DONE) && (cnt != '0)
               && rd_ready && !start;

    // state register
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        stop      = 1'b0;
        core_en   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                core_en = 1'b1;
                busy    = 1'b1;
                stop = ((lim != '0) && (cyc == lim - CYC_W'(1)))
                     || (!wrap && wr && (cnt == CW'(DEPTH-1)));
                if (stop) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    go        = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // run config, cycle counter, pointers and occupancy
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            cyc   <= '0;
            lim   <= '0;
            wrap  <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (go) begin
            cyc   <= '0;
            lim   <= cycle_limit;
            wrap  <= wrap_mode;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (state == ST_RUN) begin
            cyc <= cyc + CYC_W'(1);
            if (wr) begin
                wptr <= wptr + AW'(1);
                if (full) begin
                    rptr  <= rptr + AW'(1);
                    ovf_q <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end else if (pop) begin
            rptr <= rptr + AW'(1);
            cnt  <= cnt - CW'(1);
        end
    end

    philv_trace_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wptr),
        .wdata ({tr_pc, tr_instr, tr_alu}),
        .raddr (rptr),
        .rdata (rdat)
    );

    assign rd_valid = (state == ST_DONE) && (cnt != '0);
    assign rd_data  = (cnt != '0) ? rdat : '0;
    assign count    = cnt;
    assign ovf      = ovf_q;

endmodule

// File: doc/philv_trace_unit.md
# philv_trace_unit

Synthesizable run-control and trace-capture unit for the Philosophy V core. It gates the core's advance for a programmable number of cycles. Each cycle it captures per-cycle records {PC, instruction, ALU result} into a DEPTH-entry buffer, with either stop-when-full or circular (keep-newest) policy. After the run, it drains the records through a valid/ready port. It sits beside `philosophy_v_core` and replaces fixed-cycle, print-per-edge tracing with parametrised, on-chip capture.

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC and ALU result
- `DEPTH`, 16, trace entries; power of two, ≥2
- `CYC_W`, 16, width of cycle limit/counter

Ports:
- `clk`  in  1  core clock
- `rstb`  in  1  reset, asynchronous, active-high (one clock; reset asynchronous and active-high)
- `start`  in  1  single-cycle run request
- `cycle_limit`  in  CYC_W  run length in cycles; 0 = unlimited; sampled on accepted `start`
- `wrap_mode`  in  1  0 = stop when full, 1 = overwrite oldest; sampled on accepted `start`
- `core_en`  out  1  core advance enable
- `tr_valid`  in  1  core presents a record this cycle
- `tr_pc`  in  XLEN  record PC
- `tr_instr`  in  32  record instruction
- `tr_alu`  in  XLEN  record ALU result
- `rd_valid`  out  1  record available
- `rd_ready`  in  1  consumer accepts record
- `rd_data`  out  2*XLEN+32  {pc, instr, alu}, oldest first
- `count`  out  $clog2(DEPTH+1)  entries held
- `busy`  out  1  state is RUN
- `done`  out  1  state is DONE
- `ovf`  out  1  sticky; at least one entry overwritten this run

## Operation
- States IDLE, RUN, DONE.
- Reset: state IDLE; `core_en`, `busy`, `done`, `rd_valid`, `ovf` = 0; `count` = 0; pointers = 0; `rd_data` = 0.
- IDLE:
  - `start` → RUN.
  - Clears cycle counter, pointers, `count`, `ovf`.
  - Latches `cycle_limit` and `wrap_mode`.
- RUN:
  - `core_en` = 1; cycle counter increments every cycle.
  - `tr_valid` = 1 writes the record at the write pointer; `count` increments.
  - Exit to DONE at the end of the cycle in which either holds:
    - counter equals latched limit − 1 (limit ≠ 0);
    - `wrap_mode` = 0 and the write makes `count` = DEPTH.
  - Full with `wrap_mode` = 1: the write overwrites the oldest entry; read pointer advances; `count` stays DEPTH; `ovf` sets.
  - `start` is ignored. `rd_valid` = 0.
- DONE:
  - `core_en` = 0; `done` = 1.
  - `rd_valid` = (`count` ≠ 0). A pop on `rd_valid && rd_ready` advances the read pointer and decrements `count`.
  - `start` → RUN with full clearing, as from IDLE. A pop in the same cycle is discarded.
- `rd_data` = entry at read pointer when `count` ≠ 0, else 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- `core_en`, `busy`, `done` decode registered state; they change one cycle after the triggering edge.
- `start` accepted at edge k gives `core_en` = 1 from cycle k+1 for exactly `cycle_limit` cycles (limit ≠ 0), unless stopped by full.
- Capture occurs at the same edge as `tr_valid`; zero added latency.
- `rd_data`/`rd_valid` are combinational from registered storage. The next record is presented the cycle after a pop.
- Async reset mid-RUN: `core_en` drops immediately; buffer contents are discarded (`count` = 0).

## Configuration
- `PHILV_TRACE_TRIG_EN` defined:
  - adds input `trig_pc` (XLEN);
  - in RUN, capture stays disarmed until a `tr_valid` cycle with `tr_pc == trig_pc`; that record and all later ones are captured;
  - the cycle counter runs from `start` regardless of arming;
  - arming clears on `start` and on reset.
- Undefined: no port; capture is armed from the first RUN cycle.

## Structure
- Package `philv_trace_pkg`:
  - state enum `trace_state_t`;
  - record struct `trace_rec_t` {pc, instr, alu}, parametrised via localparam widths;
  - localparam `TRACE_REC_W`.
- Sub-module `philv_trace_ram`: DEPTH × `TRACE_REC_W`, one synchronous write port, asynchronous read, no reset.

## Test plan
- DEPTH=4, limit=3, wrap=0, `tr_valid` every cycle, PCs 0x0/0x4/0x8 → `core_en` high exactly 3 cycles; `done`; drain yields 0x0, 0x4, 0x8; `count` 3→0; `ovf` = 0.
- DEPTH=4, limit=10, wrap=0 → stops after 4th capture (4 `core_en` cycles); `count` = 4; `ovf` = 0.
- DEPTH=4, limit=6, wrap=1, PCs 0x0..0x14 → drain yields 0x8, 0xC, 0x10, 0x14; `ovf` = 1.
- `rd_ready` toggling 1/0 during drain → each record delivered exactly once, in order, held stable while `rd_ready` = 0.
- `rstb` pulsed mid-RUN → `core_en`, `busy`, `count` read 0 during reset; a new `start` runs cleanly.
- With `PHILV_TRACE_TRIG_EN`, `trig_pc` = 0x8, limit=5, PCs 0x0..0x10 → captures 0x8, 0xC, 0x10 only.
